dmem_responder: RTL and testbench

// - Data-memory responder: the slave end of the memory stage's load/store request interface.
// - Accepts one word-aligned request at a time and holds a DEPTH-word on-chip array.
// - Returns read data, or a write acknowledge, a fixed LATENCY cycles after acceptance.
// - The memory stage drives stall_from_memory while its request is outstanding (req_ready low / no resp).

---
 rtl/dmem_responder.sv | 121 ++++++++++++
 tb/tb_dmem_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store slave over a DEPTH-word array.
// The response (read data or store ack) is a one-cycle pulse LATENCY cycles after accept.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [31:0]   mem [DEPTH];

  logic          we_q, err_q;
  logic [3:0]    be_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;

  logic          accept, commit, addr_err;
  logic          a_we, a_err;
  logic [3:0]    a_be;
  logic [AW-1:0] a_idx;
  logic [31:0]   a_wdata;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign addr_err  = (req_addr[1:0] != 2'b00) | ((req_addr >> (AW + 2)) != 32'd0);

  // With LATENCY==1 the access happens on the accept edge itself, so it uses the live request.
  always_comb begin
    if (state == IDLE) begin
      a_we    = req_we;
      a_be    = req_be;
      a_idx   = req_addr[AW+1:2];
      a_wdata = req_wdata;
      a_err   = addr_err;
    end else begin
      a_we    = we_q;
      a_be    = be_q;
      a_idx   = idx_q;
      a_wdata = wdata_q;
      a_err   = err_q;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    commit   = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (LATENCY == 1) begin
          state_nx = RESP;
          commit   = 1'b1;
        end else begin
          state_nx = BUSY;
          cnt_nx   = CW'(LATENCY - 2);
        end
      end
      BUSY: if (cnt == '0) begin
        state_nx = RESP;
        commit   = 1'b1;
      end else begin
        cnt_nx = cnt - 1'b1;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      if (accept) begin
        we_q    <= req_we;
        be_q    <= req_be;
        idx_q   <= req_addr[AW+1:2];
        wdata_q <= req_wdata;
        err_q   <= addr_err;
      end
      resp_valid <= commit;
      resp_err   <= commit & a_err;
      resp_rdata <= (commit && !a_we && !a_err) ? mem[a_idx] : 32'd0;
    end
  end

  // Array is never cleared; a store commits only on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (rst_n && commit && a_we && !a_err) begin
      for (int b = 0; b < 4; b++)
        if (a_be[b]) mem[a_idx][8*b +: 8] <= a_wdata[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed cases plus a randomized load/store mix against a word-array model.
module tb_dmem_responder;
  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [3:0]  req_be = 4'h0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_chk = 0;
  int n_pass = 0;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_be(req_be),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One full transaction; checks handshake, latency, single pulse and output return-to-zero.
  task automatic xact(input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rd, output logic er);
    int n, lat, np;
    rd = '0; er = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_be = ~be; req_addr = $urandom; req_wdata = $urandom;
    lat = 0; np = 0;
    for (int k = 1; k <= LATENCY + 3; k++) begin
      @(negedge clk);
      if (k <= LATENCY) chk("ready_low", {31'd0, req_ready}, 32'd0);
      if (resp_valid) begin
        if (np == 0) begin lat = k; rd = resp_rdata; er = resp_err; end
        np++;
      end else if (k == LATENCY + 1) begin
        chk("rdata_idle", resp_rdata, 32'd0);
        chk("err_idle", {31'd0, resp_err}, 32'd0);
      end
    end
    chk("latency", lat, LATENCY);
    chk("pulses", np, 1);
  endtask

  logic [31:0] rd;
  logic        er;
  logic [31:0] b_addr[3];
  logic [31:0] b_exp[3];
  int          acc_cyc[3];
  int          na, np, nlow;
  logic [31:0] mdl[16];
  logic [31:0] w, a, e_rd;
  logic [3:0]  be;
  logic        e_er;
  int          op, i;
  logic        acc;

  initial begin
    // async reset without any clock edge
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    xact(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, er);
    chk("st_rdata", rd, 32'd0);
    chk("st_err", {31'd0, er}, 32'd0);
    xact(1'b0, 4'h0, 32'h10, 32'h0, rd, er);
    chk("ld_10", rd, 32'hDEADBEEF);
    chk("ld_10_err", {31'd0, er}, 32'd0);

    xact(1'b1, 4'hF, 32'h20, 32'h11223344, rd, er);
    xact(1'b1, 4'h5, 32'h20, 32'hAABBCCDD, rd, er);
    xact(1'b0, 4'hF, 32'h20, 32'h0, rd, er);
    chk("ld_be", rd, 32'h11BB33DD);

    xact(1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, rd, er);
    xact(1'b0, 4'h0, 32'h20, 32'h0, rd, er);
    chk("be0_noop", rd, 32'h11BB33DD);

    xact(1'b1, 4'hF, 32'h0, 32'hCAFEF00D, rd, er);
    xact(1'b0, 4'h0, 32'h13, 32'h0, rd, er);
    chk("mis_err", {31'd0, er}, 32'd1);
    chk("mis_rdata", rd, 32'd0);
    xact(1'b1, 4'hF, 32'h1000, 32'h12345678, rd, er);
    chk("oor_err", {31'd0, er}, 32'd1);
    xact(1'b0, 4'h0, 32'h0, 32'h0, rd, er);
    chk("oor_nowrite", rd, 32'hCAFEF00D);
    chk("oor_nowrite_err", {31'd0, er}, 32'd0);

    // back-to-back loads with req_valid held high
    b_addr[0] = 32'h10; b_exp[0] = 32'hDEADBEEF;
    b_addr[1] = 32'h20; b_exp[1] = 32'h11BB33DD;
    b_addr[2] = 32'h0;  b_exp[2] = 32'hCAFEF00D;
    na = 0; np = 0; nlow = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_be = 4'hF; req_addr = b_addr[0];
    for (int cyc = 0; cyc < 14; cyc++) begin
      acc = req_valid && req_ready;
      if (!req_ready) nlow++;
      if (resp_valid) begin
        if (np < 3) chk("b2b_rdata", resp_rdata, b_exp[np]);
        np++;
      end
      @(posedge clk); #1;
      if (acc) begin
        acc_cyc[na] = cyc;
        na++;
        if (na == 3) req_valid = 1'b0;
        else req_addr = b_addr[na];
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b_accepts", na, 3);
    chk("b2b_pulses", np, 3);
    chk("b2b_ready_low", nlow, 6);
    if (na == 3) begin
      chk("b2b_gap0", acc_cyc[1] - acc_cyc[0], LATENCY + 1);
      chk("b2b_gap1", acc_cyc[2] - acc_cyc[1], LATENCY + 1);
    end

    // reset while a store is pending in BUSY
    xact(1'b1, 4'hF, 32'h40, 32'h9, rd, er);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_addr = 32'h40; req_wdata = 32'h5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid_busy", {31'd0, req_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    np = 0;
    repeat (5) begin @(negedge clk); if (resp_valid) np++; end
    chk("mid_no_resp", np, 0);
    xact(1'b0, 4'h0, 32'h40, 32'h0, rd, er);
    chk("mid_uncommitted", rd, 32'h9);
    xact(1'b0, 4'h0, 32'h10, 32'h0, rd, er);
    chk("mid_committed_kept", rd, 32'hDEADBEEF);

    // randomized mix against a 16-word model at 0x100..0x13C
    for (i = 0; i < 16; i++) begin
      mdl[i] = $urandom;
      xact(1'b1, 4'hF, 32'h100 + 4 * i, mdl[i], rd, er);
    end
    for (int t = 0; t < 80; t++) begin
      op = $urandom_range(0, 5);
      i  = $urandom_range(0, 15);
      w  = $urandom;
      be = 4'($urandom);
      a  = 32'h100 + 4 * i;
      e_er = 1'b0;
      if (op == 4) begin a = a | 32'($urandom_range(1, 3)); e_er = 1'b1; end
      if (op == 5) begin a = a | (32'd1 << $urandom_range(12, 31)); e_er = 1'b1; end
      if (op == 1 || op == 3) begin
        xact(1'b1, be, a, w, rd, er);
        if (!e_er)
          for (int b = 0; b < 4; b++) if (be[b]) mdl[i][8*b +: 8] = w[8*b +: 8];
        e_rd = 32'd0;
      end else begin
        xact(op >= 4 ? $urandom_range(0, 1) == 1 : 1'b0, be, a, w, rd, er);
        e_rd = e_er ? 32'd0 : mdl[i];
      end
      chk("rnd_rdata", rd, e_rd);
      chk("rnd_err", {31'd0, er}, {31'd0, e_er});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
